// File: rtl/hilo_mpy_ctrl.sv
// HI/LO multiply controller: latches operands for an external 32x32 signed
// multiplier, waits LAT cycles, then captures HI/LO. Optional macro MULTU_EN adds unsigned MULTU.
module hilo_mpy_ctrl #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_u,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        mfhi,
  input  logic        mflo,
  output logic [31:0] mpy_s,
  output logic [31:0] mpy_t,
  input  logic [63:0] product,
  output logic        busy,
  output logic        stall,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_op_u;
  logic [31:0] r_mpy_s;
  logic [31:0] r_mpy_t;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_rdata_q;
  logic [31:0] w_hi_cap;
  logic        w_busy;
  logic [31:0] w_rd_idle;

`ifdef MULTU_EN
  // Signed product plus 2^32*(s31*t + t31*s) yields the unsigned product.
  logic [31:0] w_corr;
  always_comb begin
    w_corr = 32'd0;
    if (r_op_u) begin
      w_corr = (r_mpy_s[31] ? r_mpy_t : 32'd0) + (r_mpy_t[31] ? r_mpy_s : 32'd0);
    end
  end
  assign w_hi_cap = product[63:32] + w_corr;
`else
  logic w_unused_op;
  assign w_unused_op = r_op_u;
  assign w_hi_cap    = product[63:32];
`endif

  assign w_busy    = (r_state == S_BUSY);
  assign w_rd_idle = mfhi ? r_hi : (mflo ? r_lo : 32'd0);

  always_comb begin
    stall = 1'b0;
    if (w_busy) begin
      stall = start | mthi | mtlo | mfhi | mflo;
    end else begin
      stall = start & (mthi | mtlo);
    end
  end

  // While busy the read port freezes on whatever it last presented.
  assign rdata = w_busy ? r_rdata_q : w_rd_idle;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_op_u    <= 1'b0;
      r_mpy_s   <= 32'd0;
      r_mpy_t   <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_rdata_q <= 32'd0;
    end else begin
      r_rdata_q <= rdata;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mpy_s <= rs;
            r_mpy_t <= rt;
            r_op_u  <= op_u;
            r_cnt   <= CNT_INIT;
            r_state <= S_BUSY;
          end else begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        S_BUSY: begin
          if (r_cnt == 4'd0) begin
            r_hi    <= w_hi_cap;
            r_lo    <= product[31:0];
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mpy_s = r_mpy_s;
  assign mpy_t = r_mpy_t;
  assign busy  = w_busy;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_hilo_mpy_ctrl.sv
// Scoreboard bench for hilo_mpy_ctrl with a behavioural signed multiplier.
module tb_hilo_mpy_ctrl;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset, start, op_u, mthi, mtlo, mfhi, mflo;
  logic [31:0] rs, rt, wdata;
  logic [31:0] mpy_s, mpy_t, rdata, hi, lo;
  logic [63:0] product;
  logic        busy, stall;

  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  assign product = {{32{mpy_s[31]}}, mpy_s} * {{32{mpy_t[31]}}, mpy_t};

  hilo_mpy_ctrl #(.LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op_u(op_u), .rs(rs), .rt(rt),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .mfhi(mfhi), .mflo(mflo),
    .mpy_s(mpy_s), .mpy_t(mpy_t), .product(product), .busy(busy),
    .stall(stall), .rdata(rdata), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic u);
`ifdef MULTU_EN
    if (u) return {32'd0, a} * {32'd0, b};
`endif
    return {{32{a[31]}}, a} * {{32{b[31]}}, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic u);
    rs = a; rt = b; op_u = u; start = 1'b1;
    exp_q.push_back(model(a, b, u));
  endtask

  task automatic wait_done(input int n0, input string tag);
    int n = n0;
    int guard = 0;
    logic [63:0] e;
    while (busy && guard < 40) begin
      tick();
      guard++;
      if (busy) n++;
    end
    check({tag, "_timeout"}, 64'(guard >= 40), 64'd0);
    check({tag, "_lat"}, 64'(n), 64'(LAT));
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
      check({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
      $display("%s: s=0x%08h t=0x%08h hi=0x%08h lo=0x%08h busy_cycles=%0d",
               tag, mpy_s, mpy_t, hi, lo, n);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic u,
                        input string tag);
    issue(a, b, u);
    tick();
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(1, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; op_u = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    mfhi = 1'b0; mflo = 1'b0; rs = 32'd0; rt = 32'd0; wdata = 32'd0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_mpy_s", 64'(mpy_s), 64'd0);
    check("rst_mpy_t", 64'(mpy_t), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    $display("reset: busy=%0b hi=0x%08h lo=0x%08h", busy, hi, lo);

    launch(32'd3, 32'd4, 1'b0, "mul_3x4");
    launch(32'hFFFF_FFFE, 32'd3, 1'b0, "mul_neg2x3");
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "multu_ff");
    check("operand_hold_s", 64'(mpy_s), 64'hFFFF_FFFF);

    // Idle writes: both together, then LO alone; read priority
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A_5A5A;
    #1 check("wr_both_stall", 64'(stall), 64'd0);
    tick();
    mthi = 1'b0; wdata = 32'hCAFE_F00D;
    check("wr_both_hi", 64'(hi), 64'h5A5A_5A5A);
    check("wr_both_lo", 64'(lo), 64'h5A5A_5A5A);
    tick();
    mtlo = 1'b0;
    mfhi = 1'b1; mflo = 1'b1;
    #1 check("rd_prio", 64'(rdata), 64'h5A5A_5A5A);
    mfhi = 1'b0;
    #1 check("rd_lo", 64'(rdata), 64'hCAFE_F00D);
    mflo = 1'b0;
    #1 check("rd_none", 64'(rdata), 64'd0);
    $display("idle rw: hi=0x%08h lo=0x%08h", hi, lo);

    // Accesses during busy stall, are dropped, and rdata freezes
    issue(32'd3, 32'd4, 1'b0);
    mflo = 1'b1;
    #1 check("start_rd_stall", 64'(stall), 64'd0);
    check("start_rd_data", 64'(rdata), 64'hCAFE_F00D);
    tick();
    start = 1'b0; mflo = 1'b0;
    mfhi = 1'b1; mthi = 1'b1; wdata = 32'h1234_5678;
    #1 check("busy_stall", 64'(stall), 64'd1);
    check("busy_rdata_hold", 64'(rdata), 64'hCAFE_F00D);
    tick();
    mfhi = 1'b0; mthi = 1'b0;
    wait_done(int'(busy) + 1, "mul_busy_access");
    mthi = 1'b1;
    tick();
    mthi = 1'b0; mfhi = 1'b1;
    #1 check("mthi_after", 64'(rdata), 64'h1234_5678);
    check("mthi_after_stall", 64'(stall), 64'd0);
    mfhi = 1'b0;
    $display("post-busy mthi: hi=0x%08h", hi);

    // Start beats a same-cycle LO write
    issue(32'd6, 32'd7, 1'b0);
    mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
    #1 check("start_wr_stall", 64'(stall), 64'd1);
    tick();
    start = 1'b0; mtlo = 1'b0;
    wait_done(1, "mul_start_wr");

    // Second start while busy is ignored
    issue(32'h0001_0000, 32'h0001_0003, 1'b0);
    tick();
    rs = 32'd5; rt = 32'd5; start = 1'b1;
    #1 check("restart_stall", 64'(stall), 64'd1);
    tick();
    start = 1'b0;
    wait_done(int'(busy) + 1, "mul_restart");
    check("restart_mpy_s", 64'(mpy_s), 64'h0001_0000);
    tick();
    check("restart_idle", 64'(busy), 64'd0);

    for (int i = 0; i < 4; i++) begin
      launch($urandom, $urandom, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    // Reset on the first busy cycle aborts the multiply
    issue(32'd7, 32'd9, 1'b0);
    tick();
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    repeat (4) tick();
    check("abort_late_hi", 64'(hi), 64'd0);
    check("abort_late_lo", 64'(lo), 64'd0);
    check("abort_late_busy", 64'(busy), 64'd0);
    $display("abort: busy=%0b hi=0x%08h lo=0x%08h", busy, hi, lo);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
